adjust_seq_ctrl: RTL and testbench

Controller for the 4K×16 dual-port adjust memory. Port A takes USB-side writes through an auto-incrementing write pointer. Port B is sequenced on the application side: one adjust word is presented per column advance, from address 0 to a programmed swatch length. The block sits between the USB endpoint logic, the column-advance logic and the adjust memory, and it owns every address and enable of that memory.

---
 rtl/adjust_pkg.sv | 15 +
 rtl/adjust_wr_ptr.sv | 52 +++++
 rtl/adjust_seq_ctrl.sv | 119 +++++++++++
 tb/tb_adjust_seq_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/adjust_pkg.sv
// adjust_pkg: shared widths and sequencer state encoding for the adjust memory controller.
//   ADDR_W / DATA_W / DEPTH : geometry of the 4K x 16 dual-port adjust memory
//   state_t                 : sequencer states IDLE, PRIME, FETCH, READY, DONE
package adjust_pkg;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 1 << ADDR_W;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRIME = 3'd1,
      FETCH = 3'd2,
      READY = 3'd3,
      DONE  = 3'd4
   } state_t;
endpackage

// File: rtl/adjust_wr_ptr.sv
// adjust_wr_ptr: USB-side write pointer driving memory port A.
//   in  clk, reset_n            : clock, async active-low reset
//   in  load_start              : pointer and sticky flags return to 0
//   in  wr_en, wr_data          : write request and data
//   in  busy                    : sequencer busy, marks accepted writes as conflicts
//   out wr_count                : words accepted since the last load_start (0..DEPTH)
//   out wr_overflow/wr_conflict : sticky error flags
//   out mem_wea/addra/dia       : registered memory port A
module adjust_wr_ptr
   import adjust_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_start,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              busy,
   output logic [ADDR_W:0]   wr_count,
   output logic              wr_overflow,
   output logic              wr_conflict,
   output logic              mem_wea,
   output logic [ADDR_W-1:0] mem_addra,
   output logic [DATA_W-1:0] mem_dia
);
   logic [ADDR_W:0] base;
   logic            accept;
   // load_start acts first, so a same-cycle write lands at address 0;
   // the count can only reach DEPTH, so its MSB alone marks a full memory
   always_comb begin
      base   = load_start ? '0 : wr_count;
      accept = wr_en && !base[ADDR_W];
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_count    <= '0;
         wr_overflow <= 1'b0;
         wr_conflict <= 1'b0;
         mem_wea     <= 1'b0;
         mem_addra   <= '0;
         mem_dia     <= '0;
      end else begin
         mem_wea     <= accept;
         wr_count    <= base + {{ADDR_W{1'b0}}, accept};
         wr_overflow <= (wr_overflow && !load_start) || (wr_en && !accept);
         wr_conflict <= (wr_conflict && !load_start) || (accept && busy);
         if (accept) begin
            mem_addra <= base[ADDR_W-1:0];
            mem_dia   <= wr_data;
         end
      end
   end
endmodule

// File: rtl/adjust_seq_ctrl.sv
// adjust_seq_ctrl: owns both ports of the adjust memory; USB writes on port A, column-paced reads on port B.
//   in  clk, reset_n                         : clock, async active-low reset
//   in  usb_load_start, usb_wr_en, usb_wr_data : USB write side
//   out wr_count, wr_overflow, wr_conflict   : write pointer status
//   in  cfg_length, seq_start, seq_abort, col_adv : sequencer control
//   out adj_data, adj_valid, seq_busy, seq_done, col_miss : sequencer status and word
//   out mem_wea, mem_addra, mem_dia, mem_addrb ; in mem_dob : memory ports
module adjust_seq_ctrl
   import adjust_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              usb_load_start,
   input  logic              usb_wr_en,
   input  logic [DATA_W-1:0] usb_wr_data,
   output logic [ADDR_W:0]   wr_count,
   output logic              wr_overflow,
   output logic              wr_conflict,
   input  logic [ADDR_W:0]   cfg_length,
   input  logic              seq_start,
   input  logic              seq_abort,
   input  logic              col_adv,
   output logic [DATA_W-1:0] adj_data,
   output logic              adj_valid,
   output logic              seq_busy,
   output logic              seq_done,
   output logic              col_miss,
   output logic              mem_wea,
   output logic [ADDR_W-1:0] mem_addra,
   output logic [DATA_W-1:0] mem_dia,
   output logic [ADDR_W-1:0] mem_addrb,
   input  logic [DATA_W-1:0] mem_dob
);
   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
   state_t            state, state_n;
   logic [ADDR_W:0]   len, len_n;
   logic [ADDR_W-1:0] idx, idx_n, addrb_n;
   logic [DATA_W-1:0] data_n;
   logic              valid_n, miss_n;
   adjust_wr_ptr u_wr_ptr (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_start  (usb_load_start),
      .wr_en       (usb_wr_en),
      .wr_data     (usb_wr_data),
      .busy        (seq_busy),
      .wr_count    (wr_count),
      .wr_overflow (wr_overflow),
      .wr_conflict (wr_conflict),
      .mem_wea     (mem_wea),
      .mem_addra   (mem_addra),
      .mem_dia     (mem_dia)
   );
   always_comb begin
      state_n = state;
      len_n   = len;
      idx_n   = idx;
      addrb_n = mem_addrb;
      data_n  = adj_data;
      valid_n = adj_valid;
      miss_n  = col_miss;
      if (seq_abort) begin
         state_n = IDLE;
         valid_n = 1'b0;
      end else begin
         case (state)
            IDLE: if (seq_start) begin
               len_n   = (cfg_length > FULL) ? FULL : cfg_length;
               miss_n  = 1'b0;
               idx_n   = '0;
               addrb_n = '0;
               state_n = (len_n == '0) ? DONE : PRIME;
            end
            // mem_addrb was registered on entry, so mem_dob is current by the end of this cycle
            PRIME, FETCH: begin
               state_n = READY;
               data_n  = mem_dob;
               valid_n = 1'b1;
               miss_n  = col_miss || col_adv;
            end
            READY: if (col_adv) begin
               valid_n = 1'b0;
               if ({1'b0, idx} == len - 1'b1) state_n = DONE;
               else begin
                  idx_n   = idx + 1'b1;
                  addrb_n = idx + 1'b1;
                  state_n = FETCH;
               end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end
   // busy and done are registered from the next state so they line up with the state itself
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         len       <= '0;
         idx       <= '0;
         mem_addrb <= '0;
         adj_data  <= '0;
         adj_valid <= 1'b0;
         col_miss  <= 1'b0;
         seq_busy  <= 1'b0;
         seq_done  <= 1'b0;
      end else begin
         state     <= state_n;
         len       <= len_n;
         idx       <= idx_n;
         mem_addrb <= addrb_n;
         adj_data  <= data_n;
         adj_valid <= valid_n;
         col_miss  <= miss_n;
         seq_busy  <= (state_n != IDLE);
         seq_done  <= (state_n == DONE);
      end
   end
endmodule

// File: tb/tb_adjust_seq_ctrl.sv
// tb_adjust_seq_ctrl: scoreboard bench for adjust_seq_ctrl with a behavioural RAM and reference model.
module tb_adjust_seq_ctrl;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        usb_load_start, usb_wr_en, seq_start, seq_abort, col_adv;
   logic [15:0] usb_wr_data;
   logic [12:0] cfg_length;
   logic [12:0] wr_count;
   logic        wr_overflow, wr_conflict, adj_valid, seq_busy, seq_done, col_miss, mem_wea;
   logic [15:0] adj_data, mem_dia, mem_dob;
   logic [11:0] mem_addra, mem_addrb;

   logic [15:0] ram [4096];
   logic [15:0] ref_mem [4096];
   logic [27:0] wq[$];
   logic [15:0] dq[$];
   logic [27:0] we;
   logic [15:0] de;
   int          total = 0, bad = 0, m_cnt = 0, done_exp = 0, done_seen = 0;
   bit          pv = 0;

   always #5 clk = ~clk;

   adjust_seq_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .usb_load_start(usb_load_start), .usb_wr_en(usb_wr_en), .usb_wr_data(usb_wr_data),
      .wr_count(wr_count), .wr_overflow(wr_overflow), .wr_conflict(wr_conflict),
      .cfg_length(cfg_length), .seq_start(seq_start), .seq_abort(seq_abort), .col_adv(col_adv),
      .adj_data(adj_data), .adj_valid(adj_valid), .seq_busy(seq_busy), .seq_done(seq_done),
      .col_miss(col_miss), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dia(mem_dia),
      .mem_addrb(mem_addrb), .mem_dob(mem_dob)
   );

   always @(posedge clk) if (mem_wea) ram[mem_addra] <= mem_dia;
   assign mem_dob = ram[mem_addrb];

   wire [75:0] all_out = {wr_count, wr_overflow, wr_conflict, adj_data, adj_valid, seq_busy,
                          seq_done, col_miss, mem_wea, mem_addra, mem_dia, mem_addrb};

   task automatic chk(input string n, input logic [79:0] a, input logic [79:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", n, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (mem_wea) begin
            if (wq.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
               we = wq.pop_front();
               chk("wr_port", {mem_addra, mem_dia}, we);
            end
         end
         if (adj_valid && !pv) begin
            if (dq.size() == 0) chk("word_unexpected", 1, 0);
            else begin
               de = dq.pop_front();
               chk("adj_word", adj_data, de);
            end
         end
         if (seq_done) done_seen++;
         pv = adj_valid;
      end else pv = 0;
   end

   task automatic wr(input logic [15:0] d, input logic ls);
      usb_wr_en = 1; usb_wr_data = d; usb_load_start = ls;
      if (ls) m_cnt = 0;
      if (m_cnt < 4096) begin
         wq.push_back({12'(m_cnt), d});
         ref_mem[m_cnt] = d;
         m_cnt++;
      end
      @(negedge clk);
      usb_wr_en = 0; usb_load_start = 0;
   endtask

   task automatic load();
      usb_load_start = 1; m_cnt = 0;
      @(negedge clk);
      usb_load_start = 0;
   endtask

   // mode 0: random col_adv only while a word is shown; 1: col_adv every cycle; 2: every third cycle
   task automatic run_seq(input int cfg, input int mode);
      int L, consumed, cyc;
      bit v;
      L = (cfg > 4096) ? 4096 : cfg;
      for (int i = 0; i < L; i++) dq.push_back(ref_mem[i]);
      done_exp++;
      cfg_length = 13'(cfg); seq_start = 1;
      @(negedge clk);
      seq_start = 0;
      consumed = 0; cyc = 0;
      while (consumed < L && cyc < 20 * L + 20) begin
         v = adj_valid;
         col_adv = (mode == 1) || (mode == 0 && v && $urandom_range(2) == 0) || (mode == 2 && cyc % 3 == 2);
         @(negedge clk);
         if (col_adv && v) consumed++;
         cyc++;
      end
      col_adv = 0;
      chk("seq_consumed", consumed, L);
      chk("seq_done_pulse", seq_done, 1);
      chk("seq_valid_at_done", adj_valid, 0);
      @(negedge clk);
      chk("seq_busy_after", seq_busy, 0);
      chk("seq_done_single", seq_done, 0);
      chk("col_miss", col_miss, (mode == 1 && L > 0));
   endtask

   initial begin
      int consumed, cyc, n;
      bit v;
      reset_n = 0; usb_load_start = 0; usb_wr_en = 0; usb_wr_data = 0;
      cfg_length = 0; seq_start = 0; seq_abort = 0; col_adv = 0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", all_out, 0);
      reset_n = 1;
      @(negedge clk);
      chk("idle_outputs", all_out, 0);

      load();
      for (int i = 0; i < 8; i++) wr(16'h1000 + 16'(i), 0);
      chk("fill_count", wr_count, 8);
      repeat (2) @(negedge clk);
      run_seq(8, 2);
      chk("fill_done_count", done_seen, done_exp);

      repeat (6) begin
         load();
         n = $urandom_range(1, 24);
         for (int i = 0; i < n; i++) wr(16'($urandom), 0);
         chk("rand_count", wr_count, n);
         repeat (2) @(negedge clk);
         run_seq($urandom_range(1, n), $urandom_range(1));
      end

      run_seq(6, 1);
      run_seq(6, 0);
      col_adv = 1;
      repeat (3) @(negedge clk);
      col_adv = 0;
      chk("idle_col_adv_busy", seq_busy, 0);
      chk("idle_col_adv_miss", col_miss, 0);

      load();
      for (int i = 0; i < 8; i++) wr(16'($urandom), 0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) dq.push_back(ref_mem[i]);
      cfg_length = 8; seq_start = 1;
      @(negedge clk);
      seq_start = 0;
      consumed = 0; cyc = 0;
      while (consumed < 3 && cyc < 100) begin
         v = adj_valid;
         col_adv = v && $urandom_range(1) == 0;
         @(negedge clk);
         if (col_adv && v) consumed++;
         cyc++;
      end
      col_adv = 0;
      cyc = 0;
      while (!adj_valid && cyc < 10) begin @(negedge clk); cyc++; end
      chk("abort_word3_shown", adj_valid, 1);
      seq_abort = 1;
      @(negedge clk);
      seq_abort = 0;
      chk("abort_busy", seq_busy, 0);
      chk("abort_valid", adj_valid, 0);
      chk("abort_no_done", seq_done, 0);
      @(negedge clk);
      chk("abort_no_done_late", done_seen, done_exp);
      run_seq(2, 0);

      seq_abort = 1; seq_start = 1; cfg_length = 4;
      @(negedge clk);
      seq_abort = 0; seq_start = 0;
      chk("abort_beats_start", seq_busy, 0);

      load();
      chk("conflict_clear", wr_conflict, 0);
      cfg_length = 0; seq_start = 1;
      @(negedge clk);
      seq_start = 0;
      chk("zero_done", seq_done, 1);
      chk("zero_busy", seq_busy, 1);
      chk("zero_valid", adj_valid, 0);
      done_exp++;
      wr(16'hC0DE, 0);
      chk("zero_done_clear", seq_done, 0);
      chk("zero_busy_clear", seq_busy, 0);
      chk("conflict_set", wr_conflict, 1);

      load();
      for (int i = 0; i < 4097; i++) wr(16'($urandom), 0);
      chk("ovf_count", wr_count, 4096);
      chk("ovf_flag", wr_overflow, 1);
      repeat (2) @(negedge clk);
      chk("ovf_last_word", ram[4095], ref_mem[4095]);
      run_seq(5000, 1);

      load();
      for (int i = 0; i < 4; i++) wr(16'($urandom), 0);
      repeat (2) @(negedge clk);
      dq.push_back(ref_mem[0]);
      cfg_length = 4; seq_start = 1;
      @(negedge clk);
      seq_start = 0;
      cyc = 0;
      while (!adj_valid && cyc < 10) begin @(negedge clk); cyc++; end
      col_adv = 1;
      @(negedge clk);
      col_adv = 0;
      chk("fetch_busy", seq_busy, 1);
      chk("fetch_valid", adj_valid, 0);
      #2 reset_n = 0;
      #1 chk("reset_mid_outputs", all_out, 0);
      @(negedge clk);
      reset_n = 1;
      wr(16'hBEEF, 1);
      chk("ls_wr_count", wr_count, 1);
      repeat (2) @(negedge clk);
      chk("ls_wr_ram0", ram[0], 16'hBEEF);

      chk("done_total", done_seen, done_exp);
      chk("words_left", dq.size(), 0);
      chk("writes_left", wq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
